// File: rtl/decode_issue_stage.sv
// Registered RV32I decode/issue stage: decodes one instruction per handshake and
// stalls it on RAW/WAW hazards against a writeback-retired register scoreboard.
module decode_issue_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int RAW   = 5
) (
  input  logic             clk_i,
  input  logic             rsn_i,
  input  logic             instr_valid_i,
  input  logic [31:0]      instr_i,
  output logic             instr_ready_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [RAW-1:0]   read_addr_a_o,
  output logic [RAW-1:0]   read_addr_b_o,
  output logic [RAW-1:0]   write_addr_o,
  output logic             int_write_enable_o,
  output logic             use_a_o,
  output logic             use_b_o,
  output logic [XLEN-1:0]  imm_o,
  output logic             illegal_o,
  input  logic             wb_valid_i,
  input  logic [RAW-1:0]   wb_addr_i,
  input  logic             flush_i,
  output logic [NREGS-1:0] pending_o
);

  typedef enum logic [3:0] {
    C_LUI, C_AUIPC, C_JAL, C_JALR, C_BRANCH,
    C_LOAD, C_STORE, C_OPIMM, C_OP, C_ILLEGAL
  } op_class_e;

  op_class_e        op_class;
  logic [31:0]      imm32;
  logic [RAW-1:0]   dec_rs1, dec_rs2, dec_rd;
  logic             dec_we, dec_use_a, dec_use_b;
  logic             hazard, accept;
  logic [NREGS-1:0] pending_q, pending_d;

  // Addresses outside the register file (and x0) never count as busy.
  function automatic logic is_busy(input logic [NREGS-1:0] vec, input logic [RAW-1:0] a);
    is_busy = 1'b0;
    for (int r = 1; r < NREGS; r++)
      if (a == RAW'(r)) is_busy = vec[r];
  endfunction

  always_comb begin
    op_class = C_ILLEGAL;
    imm32    = 32'd0;
    unique case (instr_i[6:0])
      7'b0110111: op_class = C_LUI;
      7'b0010111: op_class = C_AUIPC;
      7'b1101111: op_class = C_JAL;
      7'b1100111: op_class = C_JALR;
      7'b1100011: op_class = C_BRANCH;
      7'b0000011: op_class = C_LOAD;
      7'b0100011: op_class = C_STORE;
      7'b0010011: op_class = C_OPIMM;
      7'b0110011: op_class = C_OP;
      default:    op_class = C_ILLEGAL;
    endcase
    unique case (op_class)
      C_LUI, C_AUIPC:         imm32 = {instr_i[31:12], 12'd0};
      C_JAL:                  imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                                       instr_i[20], instr_i[30:21], 1'b0};
      C_JALR, C_LOAD, C_OPIMM: imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      C_BRANCH:               imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                                       instr_i[30:25], instr_i[11:8], 1'b0};
      C_STORE:                imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      default:                imm32 = 32'd0;
    endcase
  end

  assign dec_rs1   = RAW'(instr_i[19:15]);
  assign dec_rs2   = RAW'(instr_i[24:20]);
  assign dec_rd    = RAW'(instr_i[11:7]);
  assign dec_we    = (op_class inside {C_LUI, C_AUIPC, C_JAL, C_JALR, C_LOAD, C_OPIMM, C_OP})
                     && (instr_i[11:7] != 5'd0);
  assign dec_use_a = op_class inside {C_JALR, C_BRANCH, C_LOAD, C_STORE, C_OPIMM, C_OP};
  assign dec_use_b = op_class inside {C_BRANCH, C_STORE, C_OP};

  // Hazards look only at registered pending bits, so a same-cycle writeback does not bypass.
  assign hazard = (dec_use_a && is_busy(pending_q, dec_rs1)) ||
                  (dec_use_b && is_busy(pending_q, dec_rs2)) ||
                  (dec_we    && is_busy(pending_q, dec_rd));

  assign instr_ready_o = rsn_i && !flush_i && !hazard && (!out_valid_o || out_ready_i);
  assign accept        = instr_valid_i && instr_ready_o;

  // Clear is applied before set so an issuing write to a retiring register stays pending.
  always_comb begin
    pending_d = pending_q;
    if (wb_valid_i)
      for (int r = 1; r < NREGS; r++)
        if (wb_addr_i == RAW'(r)) pending_d[r] = 1'b0;
    if (accept && dec_we)
      for (int r = 1; r < NREGS; r++)
        if (dec_rd == RAW'(r)) pending_d[r] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rsn_i || flush_i) pending_q <= '0;
    else                   pending_q <= pending_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      out_valid_o        <= 1'b0;
      read_addr_a_o      <= '0;
      read_addr_b_o      <= '0;
      write_addr_o       <= '0;
      int_write_enable_o <= 1'b0;
      use_a_o            <= 1'b0;
      use_b_o            <= 1'b0;
      imm_o              <= '0;
      illegal_o          <= 1'b0;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
    end else if (accept) begin
      out_valid_o        <= 1'b1;
      read_addr_a_o      <= dec_rs1;
      read_addr_b_o      <= dec_rs2;
      write_addr_o       <= dec_rd;
      int_write_enable_o <= dec_we;
      use_a_o            <= dec_use_a;
      use_b_o            <= dec_use_b;
      imm_o              <= XLEN'($signed(imm32));
      illegal_o          <= (op_class == C_ILLEGAL);
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

  assign pending_o = pending_q;

endmodule
